// File: rtl/dcm_phase_seq_if.sv
// Command/status and DCM phase-shift handshake bundle for dcm_phase_seq.
// master = control side plus DCM model; slave = the sequencer.
interface dcm_phase_seq_if #(
  parameter int unsigned PH_W = 9
);
  logic                   cmd_wr;
  logic                   cmd_rel;
  logic signed [PH_W-1:0] cmd_val;
  logic                   err_clr;
  logic                   locked;
  logic                   psdone;
  logic                   psen;
  logic                   psincdec;
  logic signed [PH_W-1:0] ph_cur;
  logic signed [PH_W-1:0] ph_tgt;
  logic                   ready;
  logic [1:0]             err;

  modport master (
    output cmd_wr, cmd_rel, cmd_val, err_clr, locked, psdone,
    input  psen, psincdec, ph_cur, ph_tgt, ready, err
  );

  modport slave (
    input  cmd_wr, cmd_rel, cmd_val, err_clr, locked, psdone,
    output psen, psincdec, ph_cur, ph_tgt, ready, err
  );
endinterface

// File: rtl/dcm_phase_seq.sv
// Closed-loop DCM variable phase-shift sequencer: steps PSEN one tap at a time toward a clamped target.
// Optional PSDONE watchdog enabled by defining DCM_PS_TIMEOUT_EN.
module dcm_phase_seq #(
  parameter int unsigned PH_W       = 9,
  parameter int          PH_MIN     = -255,
  parameter int          PH_MAX     = 255,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TO_CYC     = 1023
) (
  input  logic           dcm_clk,
  input  logic           dcm_rst,
  dcm_phase_seq_if.slave bus
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned X_W   = PH_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic signed [X_W-1:0] MIN_X = X_W'(PH_MIN);
  localparam logic signed [X_W-1:0] MAX_X = X_W'(PH_MAX);

  // Reject configurations the sequencer cannot honour.
  if (SETTLE_CYC == 0 || TO_CYC == 0 || PH_MIN > PH_MAX) begin : g_cfg_bad
    $error("dcm_phase_seq: invalid parameter set");
  end

`ifdef DCM_PS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  logic [1:0]             state_q, state_d;
  logic signed [PH_W-1:0] ph_cur_q, ph_cur_d;
  logic signed [PH_W-1:0] ph_tgt_q, ph_tgt_d;
  logic                   psen_q, psen_d;
  logic                   psincdec_q, psincdec_d;
  logic                   dir_q, dir_d;
  logic [SET_W-1:0]       set_cnt_q, set_cnt_d;
  logic [1:0]             err_q, err_d;
  logic                   ready_q, ready_d;

  logic signed [X_W-1:0]  val_x;
  logic signed [X_W-1:0]  tgt_x;
  logic signed [X_W-1:0]  sum_x;
  logic [1:0]             err_ev;

  // Saturate a widened tap value into [PH_MIN, PH_MAX].
  function automatic logic signed [PH_W-1:0] clamp_ph(input logic signed [X_W-1:0] v);
    logic signed [X_W-1:0] r;
    r = v;
    if (v < MIN_X) r = MIN_X;
    if (v > MAX_X) r = MAX_X;
    return PH_W'(r);
  endfunction

  always_comb begin
    val_x = X_W'(bus.cmd_val);
    tgt_x = X_W'(ph_tgt_q);
    sum_x = tgt_x + val_x;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ph_cur_d   = ph_cur_q;
    ph_tgt_d   = ph_tgt_q;
    psen_d     = 1'b0;
    psincdec_d = 1'b0;
    dir_d      = dir_q;
    set_cnt_d  = set_cnt_q;
    err_d      = err_q;
    err_ev     = 2'b00;
`ifdef DCM_PS_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    if (bus.cmd_wr) begin
      ph_tgt_d = bus.cmd_rel ? clamp_ph(sum_x) : clamp_ph(val_x);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.locked && (err_q == 2'b00) && (ph_cur_q != ph_tgt_q)) begin
          psen_d     = 1'b1;
          psincdec_d = (ph_tgt_q > ph_cur_q);
          dir_d      = (ph_tgt_q > ph_cur_q);
          state_d    = ST_WAIT;
`ifdef DCM_PS_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end

      ST_WAIT: begin
        if (!bus.locked) begin
          err_ev[0] = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.psdone) begin
          ph_cur_d  = dir_q ? (ph_cur_q + PH_W'(1)) : (ph_cur_q - PH_W'(1));
          set_cnt_d = SET_W'(SETTLE_CYC - 1);
          state_d   = ST_SETTLE;
`ifdef DCM_PS_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
          err_ev[1] = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d  = to_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_SETTLE: begin
        if (!bus.locked) begin
          err_ev[0] = 1'b1;
          state_d   = ST_IDLE;
        end else if (set_cnt_q == '0) begin
          state_d   = ST_IDLE;
        end else begin
          set_cnt_d = set_cnt_q - SET_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A same-cycle error event overrides the clear.
    if (bus.err_clr) err_d = 2'b00;
    err_d = err_d | err_ev;

    ready_d = (state_d == ST_IDLE) && (ph_cur_d == ph_tgt_d);
  end

  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) begin
      state_q    <= ST_IDLE;
      ph_cur_q   <= '0;
      ph_tgt_q   <= '0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      dir_q      <= 1'b0;
      set_cnt_q  <= '0;
      err_q      <= 2'b00;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_cur_q   <= ph_cur_d;
      ph_tgt_q   <= ph_tgt_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      dir_q      <= dir_d;
      set_cnt_q  <= set_cnt_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

`ifdef DCM_PS_TIMEOUT_EN
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`endif

  assign bus.psen     = psen_q;
  assign bus.psincdec = psincdec_q;
  assign bus.ph_cur   = ph_cur_q;
  assign bus.ph_tgt   = ph_tgt_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dcm_phase_seq.sv
// Directed bench for dcm_phase_seq with a DCM model answering PSEN by PSDONE three cycles later.
`timescale 1ns/1ps
module tb_dcm_phase_seq;
  localparam int unsigned PH_W   = 9;
  localparam int unsigned TO_CYC = 1023;

  logic dcm_clk = 1'b0;
  logic dcm_rst;
  always #5 dcm_clk = ~dcm_clk;

  dcm_phase_seq_if #(.PH_W(PH_W)) bus ();

  dcm_phase_seq #(
    .PH_W(PH_W), .PH_MIN(-255), .PH_MAX(255), .SETTLE_CYC(4), .TO_CYC(TO_CYC)
  ) dut (
    .dcm_clk(dcm_clk),
    .dcm_rst(dcm_rst),
    .bus(bus)
  );

  // DCM model: PSDONE three cycles after each PSEN, unless withheld.
  logic [2:0] ps_pipe;
  logic       resp_en;
  logic       man_psdone;
  always @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) ps_pipe <= 3'b000;
    else         ps_pipe <= {ps_pipe[1:0], bus.psen & resp_en};
  end
  assign bus.psdone = ps_pipe[2] | man_psdone;

  int n_inc, n_dec;
  logic signed [PH_W-1:0] hist[$];
  logic signed [PH_W-1:0] last_cur = '0;
  always @(posedge dcm_clk) begin
    if (bus.psen === 1'b1) begin
      if (bus.psincdec) n_inc++;
      else              n_dec++;
    end
    if (bus.ph_cur !== last_cur) begin
      hist.push_back(bus.ph_cur);
      last_cur = bus.ph_cur;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic rel, input int v);
    bus.cmd_wr  = 1'b1;
    bus.cmd_rel = rel;
    bus.cmd_val = PH_W'(v);
    @(negedge dcm_clk);
    bus.cmd_wr  = 1'b0;
    bus.cmd_rel = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int i = 0;
    while (bus.ready !== 1'b1 && i < budget) begin
      @(negedge dcm_clk);
      i++;
    end
    check(tag, bus.ready, 1);
  endtask

  task automatic wait_psen(input string tag, input int budget, input int cur);
    int i = 0;
    while (!(bus.psen === 1'b1 && bus.ph_cur == PH_W'(cur)) && i < budget) begin
      @(negedge dcm_clk);
      i++;
    end
    check(tag, bus.psen, 1);
  endtask

  task automatic clear_log();
    hist.delete();
    n_inc = 0;
    n_dec = 0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(negedge dcm_clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    logic signed [PH_W-1:0] exp_h[5];
    dcm_rst     = 1'b1;
    bus.cmd_wr  = 1'b0;
    bus.cmd_rel = 1'b0;
    bus.cmd_val = '0;
    bus.err_clr = 1'b0;
    bus.locked  = 1'b1;
    resp_en     = 1'b1;
    man_psdone  = 1'b0;
    n_inc       = 0;
    n_dec       = 0;

    // Reset values, then quiet idle.
    repeat (3) @(negedge dcm_clk);
    check("rst_ready", bus.ready, 1);
    check("rst_ph_cur", bus.ph_cur, 0);
    check("rst_err", bus.err, 0);
    check("rst_psen", bus.psen, 0);
    dcm_rst = 1'b0;
    repeat (20) @(negedge dcm_clk);
    check("idle_no_psen", n_inc + n_dec, 0);
    check("idle_ready", bus.ready, 1);

    // Absolute +3: first PSEN two cycles after the command.
    clear_log();
    cmd(1'b0, 3);
    check("abs3_tgt", bus.ph_tgt, 3);
    check("abs3_ready_low", bus.ready, 0);
    check("abs3_psen_c1", bus.psen, 0);
    @(negedge dcm_clk);
    check("abs3_psen_c2", bus.psen, 1);
    check("abs3_incdec", bus.psincdec, 1);
    wait_ready("abs3_ready", 200);
    check("abs3_cur", bus.ph_cur, 3);
    check("abs3_n_inc", n_inc, 3);
    check("abs3_n_dec", n_dec, 0);
    check("abs3_hist_n", hist.size(), 3);
    for (int k = 0; k < 3 && k < hist.size(); k++) check("abs3_hist", hist[k], k + 1);

    // Retarget to 2 while the 4->5 step is in flight.
    clear_log();
    cmd(1'b0, 10);
    wait_psen("rt_psen_at4", 200, 4);
    cmd(1'b0, 2);
    check("rt_tgt", bus.ph_tgt, 2);
    wait_ready("rt_ready", 300);
    check("rt_cur", bus.ph_cur, 2);
    check("rt_n_inc", n_inc, 2);
    check("rt_n_dec", n_dec, 3);
    exp_h[0] = 4; exp_h[1] = 5; exp_h[2] = 4; exp_h[3] = 3; exp_h[4] = 2;
    check("rt_hist_n", hist.size(), 5);
    for (int k = 0; k < 5 && k < hist.size(); k++) check("rt_hist", hist[k], exp_h[k]);

    // Lock lost mid-WAIT: sticky err[0], no stepping until cleared.
    clear_log();
    cmd(1'b0, 6);
    wait_psen("lk_psen", 20, 2);
    bus.locked = 1'b0;
    @(negedge dcm_clk);
    check("lk_err", bus.err, 1);
    check("lk_cur", bus.ph_cur, 2);
    bus.locked = 1'b1;
    repeat (30) @(negedge dcm_clk);
    check("lk_blocked_psen", n_inc + n_dec, 1);
    check("lk_blocked_cur", bus.ph_cur, 2);
    check("lk_err_sticky", bus.err, 1);
    check("lk_ready", bus.ready, 0);
    pulse_err_clr();
    check("lk_err_clr", bus.err, 0);
    wait_ready("lk_ready_after", 200);
    check("lk_cur_final", bus.ph_cur, 6);
    check("lk_n_inc", n_inc, 5);

    // PSDONE withheld.
    clear_log();
    resp_en = 1'b0;
    cmd(1'b0, 7);
    wait_psen("to_psen", 20, 6);
`ifdef DCM_PS_TIMEOUT_EN
    repeat (TO_CYC + 5) @(negedge dcm_clk);
    check("to_err", bus.err, 2);
    check("to_cur", bus.ph_cur, 6);
    check("to_n_psen", n_inc + n_dec, 1);
    resp_en = 1'b1;
    pulse_err_clr();
    wait_ready("to_ready", 200);
    check("to_cur_final", bus.ph_cur, 7);
`else
    repeat (2 * TO_CYC) @(negedge dcm_clk);
    check("wait_err", bus.err, 0);
    check("wait_cur", bus.ph_cur, 6);
    check("wait_ready_low", bus.ready, 0);
    check("wait_n_psen", n_inc + n_dec, 1);
    man_psdone = 1'b1;
    @(negedge dcm_clk);
    man_psdone = 1'b0;
    resp_en = 1'b1;
    wait_ready("wait_ready_after", 50);
    check("wait_cur_final", bus.ph_cur, 7);
`endif

    // Asynchronous reset in the middle of a step.
    cmd(1'b0, -5);
    wait_psen("rs_psen", 20, 7);
    dcm_rst = 1'b1;
    #1;
    check("rs_cur", bus.ph_cur, 0);
    check("rs_tgt", bus.ph_tgt, 0);
    check("rs_psen_low", bus.psen, 0);
    check("rs_ready", bus.ready, 1);
    check("rs_err", bus.err, 0);
    @(negedge dcm_clk);
    dcm_rst = 1'b0;
    @(negedge dcm_clk);

    // Relative -200 then -100 from 0 saturates at -255.
    clear_log();
    cmd(1'b1, -200);
    check("rel_tgt1", bus.ph_tgt, -200);
    cmd(1'b1, -100);
    check("rel_tgt_clamp", bus.ph_tgt, -255);
    wait_ready("rel_ready", 3000);
    check("rel_cur", bus.ph_cur, -255);
    check("rel_n_dec", n_dec, 255);
    check("rel_n_inc", n_inc, 0);

    // Target equal to ph_cur keeps ready; stray PSDONE in IDLE is ignored.
    cmd(1'b0, -255);
    check("eq_ready", bus.ready, 1);
    man_psdone = 1'b1;
    @(negedge dcm_clk);
    man_psdone = 1'b0;
    repeat (5) @(negedge dcm_clk);
    check("eq_ready_hold", bus.ready, 1);
    check("stray_cur", bus.ph_cur, -255);
    check("eq_n_dec", n_dec, 255);

    // Clamp arithmetic with the DCM unlocked: no steps, no error.
    bus.locked = 1'b0;
    cmd(1'b1, 255);
    check("cl_rel_up", bus.ph_tgt, 0);
    check("cl_ready", bus.ready, 0);
    cmd(1'b0, 255);
    check("cl_abs_max", bus.ph_tgt, 255);
    cmd(1'b1, 255);
    check("cl_sat_hi", bus.ph_tgt, 255);
    cmd(1'b1, -256);
    check("cl_rel_dn", bus.ph_tgt, -1);
    cmd(1'b0, -256);
    check("cl_abs_min", bus.ph_tgt, -255);
    cmd(1'b0, 100);
    repeat (20) @(negedge dcm_clk);
    check("ul_n_psen", n_inc + n_dec, 255);
    check("ul_err", bus.err, 0);
    check("ul_cur", bus.ph_cur, -255);
    check("ul_ready", bus.ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
